conv3x3_stream_engine: RTL and testbench

Parametrised successor to the fixed-mode 3x3 convolution stage. It takes a pre-assembled 3x3 window per pixel for NUM_CH parallel channels and applies a run-time-programmable kernel from a bank of NUM_BANKS coefficient sets. The datapath adds rounding, a per-bank shift, an optional absolute value, clamping to the pixel range and a valid/ready handshake with backpressure. It sits between the line-buffer/window generator and the pixel output formatter.

---
 rtl/conv_pkg.sv | 43 ++++
 rtl/conv_channel_mac.sv | 82 ++++++++
 rtl/conv3x3_stream_engine.sv | 158 +++++++++++++++
 tb/tb_conv3x3_stream_engine.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants, reset kernels and width helpers for the 3x3 streaming convolution engine.
package conv_pkg;

  localparam int unsigned NUM_TAPS      = 9;
  localparam int unsigned CFG_SHIFT_IDX = 9;

  function automatic int unsigned prod_width(int unsigned pix_w, int unsigned coef_w);
    return pix_w + coef_w + 1;
  endfunction

  function automatic int unsigned row_width(int unsigned pix_w, int unsigned coef_w);
    return prod_width(pix_w, coef_w) + 2;
  endfunction

  function automatic int unsigned sum_width(int unsigned pix_w, int unsigned coef_w);
    return prod_width(pix_w, coef_w) + 4;
  endfunction

  function automatic int unsigned cfg_width(int unsigned coef_w, int unsigned shift_w);
    return (coef_w > shift_w + 1) ? coef_w : shift_w + 1;
  endfunction

  function automatic int default_coef(int unsigned bank, int unsigned tap);
    int k [NUM_TAPS];
    case (bank)
      0:       k = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
      1:       k = '{0, 1, 0, 1, -4, 1, 0, 1, 0};
      2:       k = '{0, -1, 0, -1, 5, -1, 0, -1, 0};
      3:       k = '{-2, -1, 0, -1, 1, 1, 0, 1, 2};
      default: k = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    endcase
    return k[tap];
  endfunction

  function automatic int unsigned default_shift(int unsigned bank);
    return (bank == 0) ? 4 : 0;
  endfunction

  function automatic logic default_abs(int unsigned bank);
    return (bank == 1);
  endfunction

endpackage

// File: rtl/conv_channel_mac.sv
// One channel of the convolution datapath: products, row sums, then round/shift/abs/clamp.
module conv_channel_mac
  import conv_pkg::*;
#(
  parameter int unsigned PIX_W   = 8,
  parameter int unsigned COEF_W  = 8,
  parameter int unsigned SHIFT_W = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         adv,
  input  logic [NUM_TAPS*PIX_W-1:0]    pix,
  input  logic [NUM_TAPS*COEF_W-1:0]   coef,
  input  logic [SHIFT_W-1:0]           shift,
  input  logic                         abs_en,
  output logic [PIX_W-1:0]             res,
  output logic                         clamped
);

  localparam int unsigned PROD_W = prod_width(PIX_W, COEF_W);
  localparam int unsigned ROW_W  = row_width(PIX_W, COEF_W);
  localparam int unsigned SUM_W  = sum_width(PIX_W, COEF_W);
  // One extra bit so the rounding add and the negation of the most negative sum cannot wrap.
  localparam int unsigned EXT_W  = SUM_W + 1;
  localparam logic signed [EXT_W-1:0] PixMax = {{(EXT_W - PIX_W){1'b0}}, {PIX_W{1'b1}}};

  logic signed [PROD_W-1:0] prod_d [NUM_TAPS];
  logic signed [PROD_W-1:0] prod_q [NUM_TAPS];
  logic signed [ROW_W-1:0]  row_d  [3];
  logic signed [ROW_W-1:0]  row_q  [3];
  logic signed [SUM_W-1:0]  total;
  logic signed [EXT_W-1:0]  rounded, shifted, mag;
  logic [PIX_W-1:0]         res_d;
  logic                     clamped_d;

  always_comb begin
    for (int k = 0; k < NUM_TAPS; k++) begin
      prod_d[k] = PROD_W'($signed({1'b0, pix[k*PIX_W +: PIX_W]}))
                * PROD_W'($signed(coef[k*COEF_W +: COEF_W]));
    end
    for (int r = 0; r < 3; r++) begin
      row_d[r] = ROW_W'(prod_q[3*r]) + ROW_W'(prod_q[3*r+1]) + ROW_W'(prod_q[3*r+2]);
    end
  end

  always_comb begin
    total   = SUM_W'(row_q[0]) + SUM_W'(row_q[1]) + SUM_W'(row_q[2]);
    rounded = EXT_W'(total);
    if (shift != '0) begin
      rounded = rounded + (EXT_W'(1) << (shift - SHIFT_W'(1)));
    end
    shifted   = rounded >>> shift;
    mag       = (abs_en && shifted[EXT_W-1]) ? -shifted : shifted;
    res_d     = mag[PIX_W-1:0];
    clamped_d = 1'b0;
    if (mag[EXT_W-1]) begin
      res_d     = '0;
      clamped_d = 1'b1;
    end else if (mag > PixMax) begin
      res_d     = '1;
      clamped_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      prod_q <= prod_d;
      row_q  <= row_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res     <= '0;
      clamped <= 1'b0;
    end else if (adv) begin
      res     <= res_d;
      clamped <= clamped_d;
    end
  end

endmodule

// File: rtl/conv3x3_stream_engine.sv
// Streaming 3x3 convolution: bank storage, frame-synchronous kernel activation, stall control,
// sideband pipe and per-frame clamp counter around NUM_CH channel datapaths.
module conv3x3_stream_engine
  import conv_pkg::*;
#(
  parameter int unsigned PIX_W     = 8,
  parameter int unsigned COEF_W    = 8,
  parameter int unsigned NUM_CH    = 1,
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned SHIFT_W   = 4,
  localparam int unsigned BANK_W   = $clog2(NUM_BANKS),
  localparam int unsigned CFG_W    = cfg_width(COEF_W, SHIFT_W)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CH*NUM_TAPS*PIX_W-1:0] in_data,
  input  logic                             in_valid,
  input  logic                             in_sof,
  output logic                             in_ready,
  input  logic [BANK_W-1:0]                bank_sel,
  input  logic                             cfg_we,
  input  logic [BANK_W-1:0]                cfg_bank,
  input  logic [3:0]                       cfg_idx,
  input  logic [CFG_W-1:0]                 cfg_wdata,
  output logic [NUM_CH*PIX_W-1:0]          out_data,
  output logic                             out_valid,
  output logic                             out_sof,
  input  logic                             out_ready,
  output logic [15:0]                      sat_cnt
);

  logic signed [COEF_W-1:0]   bank_coef_q [NUM_BANKS][NUM_TAPS];
  logic [SHIFT_W-1:0]         bank_shift_q [NUM_BANKS];
  logic                       bank_abs_q [NUM_BANKS];

  logic [NUM_TAPS*COEF_W-1:0] act_coef_q;
  logic [SHIFT_W-1:0]         act_shift_q, s2_shift_q, s3_shift_q;
  logic                       act_abs_q, s2_abs_q, s3_abs_q;

  logic [NUM_CH*NUM_TAPS*PIX_W-1:0] s1_data_q;
  logic s1_valid_q, s2_valid_q, s3_valid_q, out_valid_q;
  logic s1_sof_q, s2_sof_q, s3_sof_q, out_sof_q;
  logic adv, accept;

  logic [NUM_CH-1:0] clamp;
  logic [16:0]       clamp_n, sat_sum;
  logic [15:0]       sat_cnt_q;

  assign adv       = !out_valid_q || out_ready;
  assign accept    = in_valid && adv;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign sat_cnt   = sat_cnt_q;

  // Bank storage only; the active copy is refreshed from here on an accepted sof beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        for (int unsigned k = 0; k < NUM_TAPS; k++) begin
          bank_coef_q[b][k] <= COEF_W'(default_coef(b, k));
        end
        bank_shift_q[b] <= SHIFT_W'(default_shift(b));
        bank_abs_q[b]   <= default_abs(b);
      end
    end else if (cfg_we) begin
      for (int unsigned k = 0; k < NUM_TAPS; k++) begin
        if (cfg_idx == 4'(k)) bank_coef_q[cfg_bank][k] <= cfg_wdata[COEF_W-1:0];
      end
      if (cfg_idx == 4'(CFG_SHIFT_IDX)) begin
        bank_shift_q[cfg_bank] <= cfg_wdata[SHIFT_W-1:0];
        bank_abs_q[cfg_bank]   <= cfg_wdata[SHIFT_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NUM_TAPS; k++) begin
        act_coef_q[k*COEF_W +: COEF_W] <= COEF_W'(default_coef(0, k));
      end
      act_shift_q <= SHIFT_W'(default_shift(0));
      act_abs_q   <= default_abs(0);
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s3_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      s1_sof_q    <= 1'b0;
      s2_sof_q    <= 1'b0;
      s3_sof_q    <= 1'b0;
      out_sof_q   <= 1'b0;
      s2_shift_q  <= '0;
      s3_shift_q  <= '0;
      s2_abs_q    <= 1'b0;
      s3_abs_q    <= 1'b0;
    end else if (adv) begin
      s1_valid_q  <= in_valid;
      s1_sof_q    <= in_valid && in_sof;
      s2_valid_q  <= s1_valid_q;
      s2_sof_q    <= s1_sof_q;
      s3_valid_q  <= s2_valid_q;
      s3_sof_q    <= s2_sof_q;
      out_valid_q <= s3_valid_q;
      out_sof_q   <= s3_sof_q;
      // The S1 beat leaving now was loaded under the current active set, so it takes that set.
      s2_shift_q  <= act_shift_q;
      s2_abs_q    <= act_abs_q;
      s3_shift_q  <= s2_shift_q;
      s3_abs_q    <= s2_abs_q;
      if (accept && in_sof) begin
        for (int unsigned k = 0; k < NUM_TAPS; k++) begin
          act_coef_q[k*COEF_W +: COEF_W] <= bank_coef_q[bank_sel][k];
        end
        act_shift_q <= bank_shift_q[bank_sel];
        act_abs_q   <= bank_abs_q[bank_sel];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (adv) s1_data_q <= in_data;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    conv_channel_mac #(
      .PIX_W  (PIX_W),
      .COEF_W (COEF_W),
      .SHIFT_W(SHIFT_W)
    ) u_mac (
      .clk    (clk),
      .rst    (rst),
      .adv    (adv),
      .pix    (s1_data_q[c*NUM_TAPS*PIX_W +: NUM_TAPS*PIX_W]),
      .coef   (act_coef_q),
      .shift  (s3_shift_q),
      .abs_en (s3_abs_q),
      .res    (out_data[c*PIX_W +: PIX_W]),
      .clamped(clamp[c])
    );
  end

  always_comb begin
    clamp_n = '0;
    for (int c = 0; c < NUM_CH; c++) clamp_n = clamp_n + 17'(clamp[c]);
    sat_sum = {1'b0, sat_cnt_q} + clamp_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_cnt_q <= '0;
    end else if (out_valid_q && out_ready) begin
      if (out_sof_q)      sat_cnt_q <= clamp_n[15:0];
      else if (sat_sum[16]) sat_cnt_q <= 16'hFFFF;
      else                sat_cnt_q <= sat_sum[15:0];
    end
  end

endmodule

// File: tb/tb_conv3x3_stream_engine.sv
// Scoreboard bench for conv3x3_stream_engine: directed windows, hand-computed results.
module tb_conv3x3_stream_engine;

  typedef int win_t [9];

  typedef struct {
    int    data;
    int    sof;
    int    sat;
    int    acc_cyc;
    bit    chk_lat;
    string name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [71:0] in_data;
  logic        in_valid, in_sof, in_ready;
  logic [1:0]  bank_sel, cfg_bank;
  logic        cfg_we;
  logic [3:0]  cfg_idx;
  logic [7:0]  cfg_wdata;
  logic [7:0]  out_data;
  logic        out_valid, out_sof, out_ready;
  logic [15:0] sat_cnt;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   exp_sat = 0;
  bit   stall_go = 1'b0;

  conv3x3_stream_engine #(
    .PIX_W(8), .COEF_W(8), .NUM_CH(1), .NUM_BANKS(4), .SHIFT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
    .in_ready(in_ready), .bank_sel(bank_sel), .cfg_we(cfg_we), .cfg_bank(cfg_bank),
    .cfg_idx(cfg_idx), .cfg_wdata(cfg_wdata), .out_data(out_data), .out_valid(out_valid),
    .out_sof(out_sof), .out_ready(out_ready), .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic win_t win_u(input int v);
    win_t w;
    for (int i = 0; i < 9; i++) w[i] = v;
    return w;
  endfunction

  function automatic win_t win_c(input int c, input int n);
    win_t w;
    for (int i = 0; i < 9; i++) w[i] = n;
    w[4] = c;
    return w;
  endfunction

  function automatic logic [71:0] pack(input win_t w);
    logic [71:0] d;
    for (int i = 0; i < 9; i++) d[i*8 +: 8] = 8'(w[i]);
    return d;
  endfunction

  // Integer reference: weighted sum, round-half-up shift, optional abs, clamp to 0..255.
  function automatic int model(input win_t px, input win_t k, input int sh, input bit ab,
                               output int clamped);
    int s = 0;
    for (int i = 0; i < 9; i++) s += px[i] * k[i];
    if (sh > 0) s = (s + (1 << (sh - 1))) >>> sh;
    if (ab && s < 0) s = -s;
    clamped = (s < 0 || s > 255) ? 1 : 0;
    return (s < 0) ? 0 : (s > 255) ? 255 : s;
  endfunction

  task automatic send(input win_t w, input bit sof, input int bsel, input int exp_d,
                      input int ncl, input string name, input bit lat = 1'b0,
                      input bit wr = 1'b0, input int wb = 0, input int wi = 0,
                      input int wd = 0);
    int tries = 0;
    @(negedge clk);
    in_data  = pack(w);
    in_valid = 1'b1;
    in_sof   = sof;
    bank_sel = 2'(bsel);
    if (wr) begin
      cfg_we = 1'b1; cfg_bank = 2'(wb); cfg_idx = 4'(wi); cfg_wdata = 8'(wd);
    end
    #1;
    while (!in_ready && tries < 50) begin
      @(negedge clk);
      #1;
      tries++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: got in_ready=0 for 50 cycles, required acceptance", name);
      in_valid = 1'b0;
      cfg_we   = 1'b0;
      return;
    end
    exp_sat = sof ? ncl : ((exp_sat + ncl > 65535) ? 65535 : exp_sat + ncl);
    sb.push_back('{exp_d, int'(sof), exp_sat, cyc, lat, name});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    cfg_we   = 1'b0;
  endtask

  task automatic cfg_write(input int b, input int i, input int d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_bank = 2'(b); cfg_idx = 4'(i); cfg_wdata = 8'(d);
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_drain: got %0d results outstanding, required 0", name, sb.size());
    end
    repeat (3) @(negedge clk);
  endtask

  // Downstream backpressure: a request drops out_ready for five cycles.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (stall_go) begin
        stall_go  = 1'b0;
        out_ready = 1'b0;
        repeat (5) begin
          #1;
          if (out_valid) check("t4_stall_in_ready", in_ready, 0);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on every output transfer; sat_cnt is checked one cycle later.
  initial begin
    bit    pend = 1'b0;
    int    pend_sat = 0;
    string pend_name = "";
    exp_t  e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        pend = 1'b0;
        continue;
      end
      if (pend) begin
        check({pend_name, "_sat_cnt"}, sat_cnt, pend_sat);
        pend = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got out_data=%0d, required no output", out_data);
        end else begin
          e = sb.pop_front();
          check({e.name, "_data"}, out_data, e.data);
          check({e.name, "_sof"}, out_sof, e.sof);
          if (e.chk_lat) check({e.name, "_latency"}, cyc - e.acc_cyc, 4);
          pend      = 1'b1;
          pend_sat  = e.sat;
          pend_name = e.name;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by time limit, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    win_t w, k0;
    int   ex, cl;
    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_sof = 1'b0; bank_sel = '0;
    cfg_we = 1'b0; cfg_bank = '0; cfg_idx = '0; cfg_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_sof", out_sof, 0);
    check("reset_sat_cnt", sat_cnt, 0);
    check("reset_in_ready", in_ready, 1);

    // 1: bank 0 smoothing of a flat window, with latency
    send(win_u(100), 1'b1, 0, 100, 0, "t1", 1'b1);
    drain("t1");

    // 2: bank 1 Laplacian with abs; bank_sel change without sof is ignored
    send(win_c(200, 100), 1'b1, 1, 255, 1, "t2a");
    send(win_u(100), 1'b0, 2, 0, 0, "t2b");
    drain("t2");

    // 3: bank 2 sharpen, clamping at both ends
    send(win_c(255, 0), 1'b1, 2, 255, 1, "t3a");
    send(win_c(0, 255), 1'b0, 2, 0, 1, "t3b");
    drain("t3");

    // 4: ten beats through a five-cycle stall
    for (int i = 0; i < 10; i++) begin
      if (i == 4) stall_go = 1'b1;
      send(win_u(10 * i + 5), i == 0, 0, 10 * i + 5, 0, $sformatf("t4_%0d", i));
    end
    drain("t4");

    // 5: mid-frame write stays in storage until next sof; idx 12 is ignored
    send(win_u(100), 1'b1, 0, 100, 0, "t5a");
    cfg_write(0, 4, 8);
    cfg_write(0, 12, 8'h40);
    send(win_u(100), 1'b0, 0, 100, 0, "t5b");
    k0 = '{1, 2, 1, 2, 8, 2, 1, 2, 1};
    ex = model(win_u(100), k0, 4, 1'b0, cl);
    // same-cycle write of bank 0 with its activation: activation uses the old tap
    send(win_u(100), 1'b1, 0, ex, cl, "t5c", 1'b0, 1'b1, 0, 4, 1);
    k0[4] = 1;
    ex = model(win_u(100), k0, 4, 1'b0, cl);
    send(win_u(100), 1'b1, 0, ex, cl, "t5d");
    drain("t5");

    // 7: programmed shift/abs on bank 3
    cfg_write(3, 9, 8'h11);
    k0 = '{-2, -1, 0, -1, 1, 1, 0, 1, 2};
    w = win_u(0); w[0] = 100;
    send(w, 1'b1, 3, 100, 0, "t7a");
    w = win_u(0); w[4] = 255;
    send(w, 1'b0, 3, 128, 0, "t7b");
    w = win_u(0); w[4] = 255; w[8] = 255;
    ex = model(w, k0, 1, 1'b1, cl);
    send(w, 1'b0, 3, ex, cl, "t7c");
    drain("t7");

    // 6: reset with three beats in flight
    send(win_u(50), 1'b1, 0, 0, 0, "t6_lost0");
    send(win_u(60), 1'b0, 0, 0, 0, "t6_lost1");
    send(win_u(70), 1'b0, 0, 0, 0, "t6_lost2");
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    exp_sat = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t6_no_out_valid", out_valid, 0);
    end
    check("t6_sat_cnt", sat_cnt, 0);
    send(win_u(100), 1'b0, 3, 100, 0, "t6_active_bank0");
    send(win_u(100), 1'b1, 1, 0, 0, "t6_bank1");
    send(win_u(100), 1'b1, 0, 100, 0, "t6_bank0_restored");
    drain("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
